// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampled UART receiver.
// Holds the FSM state encoding, sample positions, baud divider and majority helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ARM    = 3'd0,
        IDLE   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam int OS = 16;

    // Three samples straddle the middle of each 16-tick bit cell.
    localparam logic [3:0] SMP_FIRST = 4'd7;
    localparam logic [3:0] SMP_MID   = 4'd8;
    localparam logic [3:0] SMP_LAST  = 4'd9;
    localparam logic [3:0] S_END     = 4'd15;

    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running clock divider emitting a one-cycle tick every DIV enabled cycles.
// A synchronous clear restarts the period so the first tick lands DIV cycles later.
module uart_baud_tick #(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // Divider counter with registered tick output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == CW'(DIV - 1)) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampled with 2-of-3 mid-bit majority, valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit and a parity_err pulse output.
module uart_rx_os16 #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);
    import uart_pkg::*;

    localparam int DIV = baud_div(CLK_HZ, BAUD, OS);

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t     state, state_nx;
    logic       sync1, rxs, rxs_d;
    logic       tick, tick_en, tick_clr;
    logic [3:0] s;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [1:0] smp;
    logic       maj, at_eval, at_end;
    logic       done, ferr, par_bad;

    assign maj      = maj3(smp[0], smp[1], rxs);
    assign at_eval  = tick && (s == SMP_LAST);
    assign at_end   = tick && (s == S_END);
    assign tick_en  = (state != IDLE);
    assign tick_clr = (state == IDLE) && (state_nx == START);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARM;
        end else begin
            state <= state_nx;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr;

    // Remembers a parity mismatch until the stop bit decides the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr;
            if (tick_clr) begin
                par_bad <= 1'b0;
            end else if (perr) begin
                par_bad <= 1'b1;
            end
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    // Next-state logic; stop is judged at the last sample, not the end of the bit.
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr     = 1'b0;
`endif
        case (state)
            ARM:     state_nx = rxs ? IDLE : ARM;
            IDLE:    state_nx = (rxs_d && !rxs) ? START : IDLE;
            START: begin
                if (at_eval && maj) begin
                    state_nx = IDLE;
                end else if (at_end) begin
                    state_nx = DATA;
                end else begin
                    state_nx = START;
                end
            end
            DATA: begin
                if (at_end && (bit_cnt == 3'd7)) begin
                    state_nx = AFTER_DATA;
                end else begin
                    state_nx = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                perr     = at_eval && (maj != ^shift);
                state_nx = at_end ? STOP : PARITY;
            end
`endif
            STOP: begin
                if (at_eval) begin
                    state_nx = maj ? IDLE : ARM;
                    done     = maj && !par_bad;
                    ferr     = !maj;
                end else begin
                    state_nx = STOP;
                end
            end
            default: state_nx = ARM;
        endcase
    end

    // Tick/bit counters, sample capture and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s       <= 4'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'd0;
            smp     <= 2'b00;
        end else if (state == IDLE) begin
            s       <= 4'd0;
            bit_cnt <= 3'd0;
        end else if (tick) begin
            s <= s + 4'd1;
            if (s == SMP_FIRST) smp[0] <= rxs;
            if (s == SMP_MID)   smp[1] <= rxs;
            if ((state == DATA) && (s == SMP_LAST)) shift <= {maj, shift[7:1]};
            if ((state == DATA) && (s == S_END))    bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Output holding register: a new byte overwrites only if the old one is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= 1'b0;
            busy      <= (state_nx != IDLE);
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: directed frames plus random bytes and baud skew.
// Runs at a scaled line rate (128 clk/bit) so the whole run stays short.
`timescale 1ns/1ps
module tb_uart_rx_os16;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 93750;
    localparam int BIT    = CLK_HZ / BAUD;

    logic       clk, rst, rx, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    uart_rx_os16 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_vrise  = 0;
    int         n_ferr   = 0;
    int         n_ovr    = 0;
    int         n_got    = 0;
    logic       valid_d  = 1'b0;
    logic [7:0] got_mem [0:63];

    // Event monitor: accepted bytes, valid rises, error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready && n_got < 64) begin
                got_mem[n_got] <= rx_data;
                n_got          <= n_got + 1;
            end
            if (frame_err)            n_ferr  <= n_ferr + 1;
            if (overrun)              n_ovr   <= n_ovr + 1;
            if (rx_valid && !valid_d) n_vrise <= n_vrise + 1;
        end
        valid_d <= rx_valid;
    end

    logic [7:0] exp_q[$];
    int         rd_idx = 0;
    int         b_vrise, b_ferr, b_ovr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_vrise = n_vrise;
        b_ferr  = n_ferr;
        b_ovr   = n_ovr;
    endtask

    // Drive a start/8 data/stop frame; optional 1-clk inversion and early cut.
    task automatic drive_frame(input logic [7:0] d, input int period, input logic stop_bit,
                               input int spike_at, input int cut_at);
        logic [9:0] fr;
        fr = {stop_bit, d, 1'b0};
        for (int c = 0; c < 10 * period && c < cut_at; c++) begin
            rx = fr[c / period] ^ (c == spike_at);
            step();
        end
    endtask

    task automatic send(input logic [7:0] d, input int period);
        drive_frame(d, period, 1'b1, -1, 10 * period);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, n_got - rd_idx, exp_q.size());
        while (exp_q.size() > 0 && rd_idx < n_got) begin
            check({tag, "_byte"}, {24'd0, got_mem[rd_idx]}, {24'd0, exp_q.pop_front()});
            rd_idx++;
        end
        exp_q.delete();
        rd_idx = n_got;
    endtask

    initial begin
        logic [7:0] d;
        int         p;

        rx = 1'b1; rst = 1'b1; rx_ready = 1'b1;
        idle(5);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(20);
        check("idle_busy", busy, 1'b0);

        // Single byte with consumer ready.
        snap();
        exp_q.push_back(8'h44);
        send(8'h44, BIT);
        idle(BIT);
        check("d_vrise", n_vrise - b_vrise, 1);
        check("d_ferr", n_ferr - b_ferr, 0);
        check("d_ovr", n_ovr - b_ovr, 0);
        check("d_busy", busy, 1'b0);
        check_model("d");

        // Two back-to-back bytes while the consumer stalls.
        snap();
        rx_ready = 1'b0;
        send(8'h55, BIT);
        send(8'hA3, BIT);
        idle(BIT);
        check("ovr_pulse", n_ovr - b_ovr, 1);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_data", rx_data, 8'h55);
        check("ovr_vrise", n_vrise - b_vrise, 1);
        rx_ready = 1'b1;
        step();
        check("ovr_clear", rx_valid, 1'b0);
        exp_q.push_back(8'h55);
        check_model("ovr");

        // Stop bit low: frame error, wait in ARM until the line goes high.
        snap();
        drive_frame(8'h7E, BIT, 1'b0, -1, 10 * BIT);
        idle(3 * BIT);
        check("fe_pulse", n_ferr - b_ferr, 1);
        check("fe_vrise", n_vrise - b_vrise, 0);
        check("fe_busy_arm", busy, 1'b1);
        rx = 1'b1;
        idle(10);
        check("fe_busy_rel", busy, 1'b0);
        exp_q.push_back(8'h31);
        send(8'h31, BIT);
        idle(BIT);
        check_model("fe_next");

        // Short low glitch on the idle line is rejected at mid start bit.
        snap();
        rx = 1'b0;
        idle(10);
        check("gl_busy_hi", busy, 1'b1);
        idle(20);
        rx = 1'b1;
        idle(120);
        check("gl_busy_lo", busy, 1'b0);
        check("gl_vrise", n_vrise - b_vrise, 0);
        check_model("gl");

        // 1-clk spike near the middle sample of data bit 3 is outvoted.
        exp_q.push_back(8'h00);
        drive_frame(8'h00, BIT, 1'b1, 4 * BIT + 73, 10 * BIT);
        idle(BIT);
        check_model("spike");

        // Baud skew of about +/-3%.
        exp_q.push_back(8'h96);
        send(8'h96, BIT - BIT * 3 / 100);
        idle(BIT);
        check_model("skew_fast");
        exp_q.push_back(8'h96);
        send(8'h96, BIT + BIT * 3 / 100);
        idle(BIT);
        check_model("skew_slow");

        // Reset mid-frame and release while the line is low.
        snap();
        drive_frame(8'hF0, BIT, 1'b1, -1, 4 * BIT + BIT / 2);
        rst = 1'b1;
        rx  = 1'b0;
        idle(20);
        check("mr_valid", rx_valid, 1'b0);
        check("mr_busy", busy, 1'b0);
        rst = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(2 * BIT);
        check("mr_vrise", n_vrise - b_vrise, 0);
        check("mr_ferr", n_ferr - b_ferr, 0);
        check_model("mr");
        exp_q.push_back(8'h0F);
        send(8'h0F, BIT);
        idle(BIT);
        check_model("mr_next");

        // Random bytes, random skew within +/-3%, random idle gaps.
        snap();
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 255));
            p = int'($urandom_range(BIT - BIT * 3 / 100, BIT + BIT * 3 / 100));
            exp_q.push_back(d);
            send(d, p);
            idle(int'($urandom_range(0, 40)));
        end
        idle(2 * BIT);
        check("rnd_ferr", n_ferr - b_ferr, 0);
        check("rnd_ovr", n_ovr - b_ovr, 0);
        check_model("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
